// File: rtl/ovl_fire_collector_if.sv
// Bundles the OVL fire collector's control, fire and status signals; master drives
// enable/clear/fire/rd_sel, slave (the collector) returns counts, capture and halt.
interface ovl_fire_collector_if #(
  parameter int NUM_CHK = 4,
  parameter int CNT_W   = 8,
  parameter int TS_W    = 16
) ();
  localparam int IDX_W = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1;

  logic               enable;
  logic               clear;
  logic [NUM_CHK-1:0] fire;
  logic [IDX_W-1:0]   rd_sel;
  logic [CNT_W-1:0]   rd_cnt;
  logic [CNT_W-1:0]   total_cnt;
  logic               err_sticky;
  logic               first_vld;
  logic [IDX_W-1:0]   first_idx;
  logic [TS_W-1:0]    first_ts;
  logic               halt_req;

  modport master (
    output enable, clear, fire, rd_sel,
    input  rd_cnt, total_cnt, err_sticky, first_vld, first_idx, first_ts, halt_req
  );

  modport slave (
    input  enable, clear, fire, rd_sel,
    output rd_cnt, total_cnt, err_sticky, first_vld, first_idx, first_ts, halt_req
  );
endinterface

// File: rtl/ovl_fire_collector.sv
// OVL fire collector: saturating per-checker/total counts, first-fail capture, halt at THRESH; 1-cycle
// latency, fires always accepted. Define OVL_FIRE_COLLECTOR_DISPLAY_EN to print each counted fire.
module ovl_fire_collector #(
  parameter int NUM_CHK = 4,
  parameter int CNT_W   = 8,
  parameter int TS_W    = 16,
  parameter int THRESH  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  ovl_fire_collector_if.slave  bus_if
);
  localparam int IDX_W = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1;
  localparam int SUM_W = CNT_W + 6;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  typedef enum logic [1:0] {ARMED, TRIPPED, HALTED} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [NUM_CHK];
  logic [CNT_W-1:0]   cnt_d [NUM_CHK];
  logic [CNT_W-1:0]   total_q, total_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [TS_W-1:0]    stamp_q;
  logic               err_q;
  logic               first_vld_q;
  logic [IDX_W-1:0]   first_idx_q;
  logic [TS_W-1:0]    first_ts_q;
  logic               halt_q;
  logic [NUM_CHK-1:0] counted;
  logic [IDX_W-1:0]   low_idx;
  logic [5:0]         pop;
  logic [SUM_W-1:0]   sum;

  always_comb begin
    counted  = bus_if.enable ? bus_if.fire : '0;
    pop      = '0;
    low_idx  = '0;
    rd_cnt_d = '0;
    // Descending scan so the last hit leaves the lowest set index in low_idx.
    for (int i = NUM_CHK - 1; i >= 0; i--) begin
      cnt_d[i] = (counted[i] && (cnt_q[i] != CNT_MAX)) ? cnt_q[i] + CNT_ONE : cnt_q[i];
      pop      = pop + 6'(counted[i]);
      if (counted[i]) low_idx = IDX_W'(i);
      if (bus_if.rd_sel == IDX_W'(i)) rd_cnt_d = cnt_q[i];
    end
    sum     = SUM_W'(total_q) + SUM_W'(pop);
    total_d = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    state_d = state_q;
    if ((state_q != HALTED) && (|counted))
      state_d = (total_d >= THRESH_C) ? HALTED : TRIPPED;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ARMED;
      for (int i = 0; i < NUM_CHK; i++) cnt_q[i] <= '0;
      total_q     <= '0;
      rd_cnt_q    <= '0;
      stamp_q     <= '0;
      err_q       <= 1'b0;
      first_vld_q <= 1'b0;
      first_idx_q <= '0;
      first_ts_q  <= '0;
      halt_q      <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      if (bus_if.clear) begin
        state_q     <= ARMED;
        for (int i = 0; i < NUM_CHK; i++) cnt_q[i] <= '0;
        total_q     <= '0;
        stamp_q     <= '0;
        err_q       <= 1'b0;
        first_vld_q <= 1'b0;
        first_idx_q <= '0;
        first_ts_q  <= '0;
        halt_q      <= 1'b0;
      end else begin
        stamp_q <= stamp_q + TS_W'(1);
        for (int i = 0; i < NUM_CHK; i++) cnt_q[i] <= cnt_d[i];
        total_q <= total_d;
        state_q <= state_d;
        halt_q  <= (state_d == HALTED);
        if (!first_vld_q && (|counted)) begin
          first_vld_q <= 1'b1;
          err_q       <= 1'b1;
          first_idx_q <= low_idx;
          first_ts_q  <= stamp_q;
        end
      end
    end
  end

`ifdef OVL_FIRE_COLLECTOR_DISPLAY_EN
  always_ff @(posedge clock) begin
    if (!reset && !bus_if.clear) begin
      for (int i = 0; i < NUM_CHK; i++)
        if (counted[i]) $display("OVL_FIRE chk=%0d ts=%0d total=%0d", i, stamp_q, total_d);
      if ((state_q != HALTED) && (state_d == HALTED))
        $display("OVL_FIRE HALT total=%0d", total_d);
    end
  end
`else
  // Display hooks compiled out; register behaviour is unaffected.
`endif

  assign bus_if.rd_cnt     = rd_cnt_q;
  assign bus_if.total_cnt  = total_q;
  assign bus_if.err_sticky = err_q;
  assign bus_if.first_vld  = first_vld_q;
  assign bus_if.first_idx  = first_idx_q;
  assign bus_if.first_ts   = first_ts_q;
  assign bus_if.halt_req   = halt_q;
endmodule

// File: tb/tb_ovl_fire_collector.sv
// Directed plus randomized bench for ovl_fire_collector against a count-level reference model.
module tb_ovl_fire_collector;
  localparam int NC   = 4;
  localparam int CW   = 4;
  localparam int TW   = 4;
  localparam int TH   = 3;
  localparam int CMAX = (1 << CW) - 1;
  localparam int TMOD = 1 << TW;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  ovl_fire_collector_if #(.NUM_CHK(NC), .CNT_W(CW), .TS_W(TW)) bus ();

  ovl_fire_collector #(.NUM_CHK(NC), .CNT_W(CW), .TS_W(TW), .THRESH(TH)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus_if (bus)
  );

  always #5 clock = ~clock;

  // Reference model: plain integer counts, clipped with min().
  int m_cnt [NC];
  int m_total, m_rd, m_stamp, m_idx, m_ts;
  bit m_vld, m_halt;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_clear_state();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_total = 0; m_stamp = 0; m_idx = 0; m_ts = 0;
    m_vld = 1'b0; m_halt = 1'b0;
  endfunction

  function automatic void model_reset();
    model_clear_state();
    m_rd = 0;
  endfunction

  function automatic void model_edge(input bit en, input bit clr, input int f, input int sel);
    int rd_next;
    int hits;
    int lowest;
    rd_next = (sel < NC) ? m_cnt[sel] : 0;
    if (clr) begin
      model_clear_state();
    end else begin
      hits = en ? (f & ((1 << NC) - 1)) : 0;
      lowest = -1;
      for (int i = 0; i < NC; i++) begin
        if (hits[i]) begin
          m_cnt[i] = min_i(m_cnt[i] + 1, CMAX);
          if (lowest < 0) lowest = i;
        end
      end
      if (hits != 0) begin
        m_total = min_i(m_total + $countones(hits), CMAX);
        if (!m_vld) begin
          m_vld = 1'b1;
          m_idx = lowest;
          m_ts  = m_stamp;
        end
        if (m_total >= TH) m_halt = 1'b1;
      end
      m_stamp = (m_stamp + 1) % TMOD;
    end
    m_rd = rd_next;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    chk({step, ".rd_cnt"},     32'(bus.rd_cnt),     32'(m_rd));
    chk({step, ".total_cnt"},  32'(bus.total_cnt),  32'(m_total));
    chk({step, ".err_sticky"}, 32'(bus.err_sticky), 32'(m_vld));
    chk({step, ".first_vld"},  32'(bus.first_vld),  32'(m_vld));
    chk({step, ".first_idx"},  32'(bus.first_idx),  32'(m_idx));
    chk({step, ".first_ts"},   32'(bus.first_ts),   32'(m_ts));
    chk({step, ".halt_req"},   32'(bus.halt_req),   32'(m_halt));
  endtask

  task automatic tick(input string step, input bit en, input bit clr, input int f, input int sel);
    bus.enable = en;
    bus.clear  = clr;
    bus.fire   = f[NC-1:0];
    bus.rd_sel = sel[1:0];
    @(posedge clock);
    model_edge(en, clr, f, sel);
    #1;
    check_all(step);
  endtask

  task automatic reset_pulse();
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable = 1'b0;
    bus.clear  = 1'b0;
    bus.fire   = '0;
    bus.rd_sel = '0;
    model_reset();

    // Reset and idle
    reset_pulse();
    for (int i = 0; i < 10; i++) tick("idle", 1'b1, 1'b0, 0, i % NC);
    chk("idle_halt", 32'(bus.halt_req), 32'd0);

    // Single fire at stamp 5, then reach THRESH=3
    reset_pulse();
    for (int i = 0; i < 5; i++) tick("pre_single", 1'b1, 1'b0, 0, 0);
    tick("single", 1'b1, 1'b0, 4'b0100, 2);
    chk("single_idx",   32'(bus.first_idx),  32'd2);
    chk("single_ts",    32'(bus.first_ts),   32'd5);
    chk("single_err",   32'(bus.err_sticky), 32'd1);
    chk("single_total", 32'(bus.total_cnt),  32'd1);
    chk("single_halt0", 32'(bus.halt_req),   32'd0);
    tick("second", 1'b1, 1'b0, 4'b0100, 2);
    chk("second_halt0", 32'(bus.halt_req), 32'd0);
    tick("third", 1'b1, 1'b0, 4'b0100, 2);
    chk("third_halt1", 32'(bus.halt_req), 32'd1);
    tick("halted_more", 1'b1, 1'b0, 4'b0001, 2);

    // Simultaneous fires after a clear
    tick("clr_a", 1'b1, 1'b1, 0, 0);
    tick("simul", 1'b1, 1'b0, 4'b1010, 0);
    chk("simul_idx",   32'(bus.first_idx), 32'd1);
    chk("simul_total", 32'(bus.total_cnt), 32'd2);
    tick("simul_rd1", 1'b1, 1'b0, 0, 1);
    chk("simul_rd1", 32'(bus.rd_cnt), 32'd1);
    tick("simul_rd3", 1'b1, 1'b0, 0, 3);
    chk("simul_rd3", 32'(bus.rd_cnt), 32'd1);

    // Enable gating, then clear beats a same-edge fire
    tick("gated", 1'b0, 1'b0, 4'b1111, 0);
    chk("gated_total", 32'(bus.total_cnt), 32'd2);
    tick("clr_fire", 1'b1, 1'b1, 4'b0001, 0);
    chk("clr_fire_total", 32'(bus.total_cnt), 32'd0);
    chk("clr_fire_vld",   32'(bus.first_vld), 32'd0);

    // Saturation at 15
    for (int i = 0; i < 20; i++) tick("sat", 1'b1, 1'b0, 4'b0001, 0);
    tick("sat_rd", 1'b1, 1'b0, 0, 0);
    chk("sat_rd_cnt", 32'(bus.rd_cnt),    32'd15);
    chk("sat_total",  32'(bus.total_cnt), 32'd15);

    // Stamp wrap: first fire on the 18th edge after reset
    reset_pulse();
    for (int i = 0; i < 17; i++) tick("pre_wrap", 1'b1, 1'b0, 0, 0);
    tick("wrap", 1'b1, 1'b0, 4'b0001, 0);
    chk("wrap_ts", 32'(bus.first_ts), 32'd1);
    tick("wrap_f2", 1'b1, 1'b0, 4'b1000, 3);
    tick("wrap_f3", 1'b1, 1'b0, 4'b1000, 3);
    chk("wrap_halt", 32'(bus.halt_req), 32'd1);

    // Asynchronous reset while HALTED
    #2;
    reset = 1'b1;
    #1;
    chk("async_halt", 32'(bus.halt_req), 32'd0);
    model_reset();
    check_all("async");
    @(negedge clock);
    reset = 1'b0;
    tick("post_reset", 1'b1, 1'b0, 4'b0010, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int f;
      f = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 0;
      tick("rand", ($urandom_range(0, 4) != 0), ($urandom_range(0, 40) == 0),
           f, int'($urandom_range(0, NC - 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
